// File: rtl/hazard_stall_unit_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_stall_unit.
// master: pipeline side (drives hazard sources, consumes control enables).
// slave : hazard_stall_unit (consumes hazard sources, drives control enables).
interface hazard_stall_unit_if #(
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             branch_taken_ex;
  logic             mc_start;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             ex_hold;
  logic             stall_active;
  logic [31:0]      stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken_ex, mc_start,
    input  pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, stall_active,
           stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken_ex, mc_start,
    output pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, stall_active,
           stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard control for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and multi-cycle EX freezes. Produces the PC write enable.
// Optional macro HAZARD_STATS_EN adds a saturating stall-cycle counter on
// stall_cycles; without it stall_cycles is tied to zero.
module hazard_stall_unit #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic           clk,
  input  logic           startin,
  hazard_stall_unit_if.slave hz
);

  localparam bit MC_EN = (MC_LAT > 1);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lu;

  // Load-use hazard: load in EX writes a register the ID instruction reads.
  assign lu = hz.ex_memread && (hz.ex_rt != '0) &&
              ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  // FSM state and freeze counter; MC_WAIT covers the MC_LAT-1 frozen cycles.
  always_ff @(posedge clk) begin
    if (startin) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hz.mc_start && MC_EN) begin
            state <= MC_WAIT;
            cnt   <= CNT_W'(MC_LAT - 1);
          end
        end
        MC_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Control enables: reset, freeze, branch flush, load-use bubble, in priority order.
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.ifid_write   = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_flush   = 1'b0;
    hz.ex_hold      = 1'b0;
    hz.stall_active = 1'b0;
    if (startin) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (state == MC_WAIT) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.ex_hold      = 1'b1;
      hz.stall_active = 1'b1;
    end else if (hz.branch_taken_ex) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (lu) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (startin) begin
      stall_cnt <= '0;
    end else if (!hz.pc_write && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cnt;
`else
  assign hz.stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a driver applies directed and random
// stimulus and queues the reference model's expectation; a monitor checks on
// the falling edge.
module tb_hazard_stall_unit;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned MC_LAT = 4;
  localparam int unsigned CNT_W  = 3;

  typedef struct packed {
    logic [5:0]  ctl;   // {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, stall_active}
    logic [31:0] stats;
  } exp_t;

  logic clk = 1'b0;
  logic startin = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: remaining frozen cycles and stall tally.
  int   freeze_left = 0;
  int   stall_tally = 0;

  hazard_stall_unit_if #(.REG_W(REG_W)) hz ();

  hazard_stall_unit #(
    .REG_W (REG_W),
    .MC_LAT(MC_LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .startin(startin),
    .hz     (hz)
  );

  always #5 clk = ~clk;

  initial begin
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.ex_memread = 1'b0;
    hz.ex_rt = '0; hz.branch_taken_ex = 1'b0; hz.mc_start = 1'b0;
  end

  // Model one cycle from the stated rules and queue the expectation.
  task automatic drive(input bit rst, input int rs, input int rt, input bit uses,
                       input bit mrd, input int ert, input bit br, input bit mc);
    exp_t e;
    bit   hazard;
    @(posedge clk);
    #1;
    startin = rst;
    hz.id_rs = REG_W'(rs); hz.id_rt = REG_W'(rt); hz.id_uses_rt = uses;
    hz.ex_memread = mrd; hz.ex_rt = REG_W'(ert);
    hz.branch_taken_ex = br; hz.mc_start = mc;
    hazard = mrd && (ert != 0) && ((ert == rs) || (uses && (ert == rt)));
`ifdef HAZARD_STATS_EN
    e.stats = 32'(stall_tally);
`else
    e.stats = 32'h0;
`endif
    if (rst) begin
      e.ctl = 6'b001100;
      freeze_left = 0;
    end else if (freeze_left > 0) begin
      e.ctl = 6'b000011;
      freeze_left--;
    end else begin
      if (br)          e.ctl = 6'b111100;
      else if (hazard) e.ctl = 6'b000100;
      else             e.ctl = 6'b110000;
      if (mc && MC_LAT > 1) freeze_left = MC_LAT - 1;
    end
    if (rst) stall_tally = 0;
    else if (e.ctl[5] == 1'b0) stall_tally++;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = exp_q.pop_front();
      act = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush,
             hz.ex_hold, hz.stall_active};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
      end
      checks++;
      if (hz.stall_cycles !== e.stats) begin
        errors++;
        $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time,
                 hz.stall_cycles, e.stats);
      end
    end
  end

  initial begin
    int waited;
    // Reset for two cycles, then quiet.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    // Load-use on rs, then same with ex_rt = 0.
    drive(0, 3, 0, 0, 1, 3, 0, 0);
    idle();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    // Branch overrides load-use on rt.
    drive(0, 1, 7, 1, 1, 7, 1, 0);
    idle();
    // Multi-cycle op: freeze, then resume.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) idle();
    // Hazard sources asserted during freeze are ignored.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 2, 2, 1, 1, 2, 1, 1);
    idle(); idle(); idle();
    // Reset mid-wait.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    // Random traffic with small register numbers to provoke matches.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0);
    end
    idle();
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Hazard control for the 5-stage pipeline; the producer of the PC `write` enable that the PC register consumes.
- Detects load-use hazards, taken-branch flushes and multi-cycle EX operations.
- Drives the PC write enable, the IF/ID write/flush, the ID/EX flush and the EX hold.
- Contains a small FSM and a latency counter for multi-cycle freezes.

Parameters:
- REG_W, 5: register-specifier width.
- MC_LAT, 4: total EX latency of a multi-cycle op, in cycles. MC_LAT >= 1.
- CNT_W, 3: stall counter width. Must satisfy 2^CNT_W > MC_LAT.

Ports:
- clk  input  1  system clock, rising edge.
- startin  input  1  synchronous active-high reset.
- id_rs  input  REG_W  rs of the instruction in ID.
- id_rt  input  REG_W  rt of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_memread  input  1  EX instruction is a load.
- ex_rt  input  REG_W  destination of the load in EX.
- branch_taken_ex  input  1  branch resolved taken in EX.
- mc_start  input  1  multi-cycle op is in its first EX cycle.
- pc_write  output  1  PC load enable; connects to the PC `write` input.
- ifid_write  output  1  IF/ID register load enable.
- ifid_flush  output  1  zero the IF/ID register.
- idex_flush  output  1  insert a bubble into ID/EX.
- ex_hold  output  1  hold the ID/EX and EX/MEM registers.
- stall_active  output  1  high while in state MC_WAIT.
- stall_cycles  output  32  stall statistics (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset startin is synchronous and active-high.
- Registered state: FSM state in {RUN, MC_WAIT} and cnt[CNT_W-1:0].
- Outputs: combinational from state, cnt and inputs.
- Reset: on a clk edge with startin=1, state<=RUN and cnt<=0.
- Outputs while startin=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, ex_hold=0, stall_active=0.
- Load-use detect: lu = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)). Register 0 never causes a hazard.
- Defaults (RUN, no event): pc_write=1, ifid_write=1, flushes=0, ex_hold=0, stall_active=0.
- RUN, priority 1, branch_taken_ex=1:
  - pc_write=1, ifid_flush=1, idex_flush=1.
  - lu is ignored, because the ID instruction is squashed.
  - Stays in RUN.
- RUN, priority 2, lu=1:
  - pc_write=0, ifid_write=0, idex_flush=1 for exactly this cycle.
  - Next cycle the load has left EX, so lu drops and the pipeline resumes. Exactly one bubble per load-use.
- RUN, priority 3, mc_start=1 and MC_LAT>1:
  - Outputs in this cycle stay at defaults.
  - Next state MC_WAIT, cnt<=MC_LAT-1.
  - mc_start with MC_LAT=1 is ignored.
  - mc_start together with branch_taken_ex or lu: the branch/lu actions apply in the current cycle, and the FSM still enters MC_WAIT.
- MC_WAIT:
  - Outputs: pc_write=0, ifid_write=0, ex_hold=1, stall_active=1, flushes=0.
  - branch_taken_ex, lu and mc_start are all ignored, because the pipeline is frozen and their sources are stable.
  - cnt decrements each cycle. When cnt==1, next state is RUN and cnt<=0.
  - MC_WAIT therefore lasts exactly MC_LAT-1 cycles. Total EX occupancy is MC_LAT cycles.
- Reset mid-MC_WAIT: startin wins. Next state is RUN, cnt=0, and the remaining count is discarded.
- Simultaneous write hazards: none. pc_write is a single combinational driver, never X after the first reset edge.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - stall_cycles is a 32-bit register, cleared by startin.
  - It increments on every clk edge where startin=0 and pc_write=0.
  - It saturates at 32'hFFFFFFFF.
- When undefined: stall_cycles is tied to 32'h0 and no counter logic is generated.

Test Plan:
- Reset: startin=1 for 2 cycles, then 0 -> during reset pc_write=0 and ifid_flush=idex_flush=1; after release, with no hazards, pc_write=1, ifid_write=1, stall_active=0.
- Load-use, rs match: ex_memread=1, ex_rt=5'd3, id_rs=5'd3 for one cycle -> exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1. Same stimulus with ex_rt=5'd0 -> no stall.
- Branch overrides load-use: branch_taken_ex=1 while lu=1 (ex_rt=id_rt=5'd7, id_uses_rt=1) -> pc_write=1, ifid_flush=1, idex_flush=1.
- Multi-cycle op, MC_LAT=4: mc_start pulse at cycle N -> stall_active=1 and pc_write=0 in cycles N+1..N+3; pc_write=1 at N+4.
- Reset mid-wait: mc_start at N, startin=1 at N+2 -> RUN at N+3, stall_active=0.
- HAZARD_STATS_EN defined: run the load-use and multi-cycle scenarios -> stall_cycles=4. Undefined -> stall_cycles=0.
